fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_pkg.sv | 19 +
 rtl/stream_skid_buf.sv | 73 +++++++
 rtl/fifo_stream_reader.sv | 90 +++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared constants for the FIFO-to-stream reader and its output buffer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fifo_stream_pkg;

  // Entries in the output buffer between the FIFO read port and the stream.
  localparam int BUF_DEPTH = 2;

  // Cycles from fifo_rd_en to fifo_valid on a Standard-mode sync_fifo.
  localparam int RD_LATENCY = 1;

  // Width needed to count buffer occupancy 0..BUF_DEPTH.
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  // Highest (buffered + in flight - popping) count at which one more read
  // can still be absorbed when its data lands RD_LATENCY cycles later.
  localparam int CREDIT_LIMIT = BUF_DEPTH - RD_LATENCY;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer; head is registered, occupancy 0..2.
// Latency: a push is visible at the head one cycle later (when buffer was empty).
// Backpressure: none upstream; a push into a full buffer without a pop is dropped and flagged.
//
// Ports: clock, reset (async active-low); push/push_data write the tail;
// pop removes the head (ignored when empty); head_valid/head_data present the
// oldest entry; occupancy is the entry count; dropped pulses when a push is lost.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  dropped
);

  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] slot0;  // head
  logic [DATA_WIDTH-1:0] slot1;  // second entry
  logic [OCC_W-1:0]      occ;
  logic                  pop_ok;

  assign pop_ok     = pop & (occ != '0);
  assign head_valid = (occ != '0);
  assign head_data  = slot0;
  assign occupancy  = occ;
  assign dropped    = push & ~pop_ok & (occ == OCC_FULL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ   <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occ == '0) begin
            slot0 <= push_data;
            occ   <= occ + 1'b1;
          end else if (occ == OCC_ONE) begin
            slot1 <= push_data;
            occ   <= occ + 1'b1;
          end
          // full: word is dropped, contents untouched
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 1'b1;
        end
        2'b11: begin
          // pop_ok implies occ is 1 or 2; occupancy stays the same
          if (occ == OCC_ONE) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a sync_fifo and presents it as a valid/ready packet stream with beat index and last.
// Latency: 2 cycles from fifo_rd_en to m_valid; 1 beat/clock sustained with m_ready high.
// Backpressure: reads are issued only when buffer+in-flight space remains; data arriving with no space is dropped and err_overflow latches.
//
// Ports: clock, reset (async active-low); enable gates new reads;
// fifo_rd_en/fifo_valid/fifo_dout/fifo_empty connect to the FIFO read side;
// m_valid/m_ready/m_data/m_last form the stream; beat_count is the beat index
// within the packet; err_overflow is a sticky drop flag.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  output logic                       fifo_rd_en,
  input  logic                       fifo_valid,
  input  logic [DATA_WIDTH-1:0]      fifo_dout,
  input  logic                       fifo_empty,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_last,
  output logic [$clog2(PKT_LEN)-1:0] beat_count,
  output logic                       err_overflow
);

  localparam int                BEAT_W    = $clog2(PKT_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
  localparam logic [OCC_W:0]    CREDIT    = (OCC_W + 1)'(CREDIT_LIMIT);

  logic              in_flight;
  logic              run;
  logic              pop;
  logic              dropped;
  logic              buf_valid;
  logic [OCC_W-1:0]  occupancy;
  logic [OCC_W:0]    outstanding;
  logic [BEAT_W-1:0] beat;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_valid),
    .push_data  (fifo_dout),
    .pop        (pop),
    .head_valid (buf_valid),
    .head_data  (m_data),
    .occupancy  (occupancy),
    .dropped    (dropped)
  );

  assign pop = buf_valid & m_ready;

  // Words that will occupy the buffer next cycle if no new read is issued.
  assign outstanding = {1'b0, occupancy}
                     + {{OCC_W{1'b0}}, in_flight}
                     - {{OCC_W{1'b0}}, pop};

  // run is cleared asynchronously by reset and set on the first edge after
  // release, so no read can be requested before that edge.
  assign fifo_rd_en = run & enable & ~fifo_empty & (outstanding <= CREDIT);

  assign m_valid    = buf_valid;
  assign m_last     = buf_valid & (beat == LAST_BEAT);
  assign beat_count = beat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run          <= 1'b0;
      in_flight    <= 1'b0;
      beat         <= '0;
      err_overflow <= 1'b0;
    end else begin
      run       <= 1'b1;
      in_flight <= fifo_rd_en;
      if (pop) begin
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
      if (dropped) begin
        err_overflow <= 1'b1;
      end
    end
  end

endmodule
